// File: rtl/acc_pkg.sv
// Shared opcodes, shifter control encodings and sequencer state for the accumulator shifter sequencer.
// Latency: n/a (declarations and pure helper functions only).
// Backpressure: n/a. Optional feature macro: ACC_ROTATE_EN (makes ROL/ROR legal).
package acc_pkg;

  localparam logic [2:0] ACC_OP_NOP  = 3'b000;
  localparam logic [2:0] ACC_OP_LOAD = 3'b001;
  localparam logic [2:0] ACC_OP_CLR  = 3'b010;
  localparam logic [2:0] ACC_OP_SET  = 3'b011;
  localparam logic [2:0] ACC_OP_SHL  = 3'b100;
  localparam logic [2:0] ACC_OP_SHR  = 3'b101;
  localparam logic [2:0] ACC_OP_ROL  = 3'b110;
  localparam logic [2:0] ACC_OP_ROR  = 3'b111;

  localparam logic [1:0] SH_HOLD  = 2'b00;
  localparam logic [1:0] SH_LOAD  = 2'b01;
  localparam logic [1:0] SH_LEFT  = 2'b10;
  localparam logic [1:0] SH_RIGHT = 2'b11;

`ifdef ACC_ROTATE_EN
  localparam logic ROT_EN = 1'b1;
`else
  localparam logic ROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Shift and rotate opcodes all have the top bit set.
  function automatic logic op_is_shift(input logic [2:0] op);
    return op[2];
  endfunction

  // Left-going ops (SHL, ROL) have bit 0 clear.
  function automatic logic op_is_left(input logic [2:0] op);
    return op[2] & ~op[0];
  endfunction

  // Rotates are only legal when the rotate feature is built in.
  function automatic logic op_legal(input logic [2:0] op);
    return ROT_EN | ~(op[2] & op[1]);
  endfunction

endpackage

// File: rtl/acc_shift_seq_if.sv
// Command and shifter-control bundle between control unit, sequencer and accumulator shifter.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready handshake; requester holds the command until ready.
interface acc_shift_seq_if #(
  parameter int N = 8
);
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [2:0]   req_amt;
  logic         req_fill;
  logic [N-1:0] req_data;
  logic [N-1:0] acc_q;
  logic         sh_clr_n;
  logic         sh_set_n;
  logic [1:0]   sh_ctrl;
  logic [2:0]   sh_num;
  logic         sh_ls;
  logic         sh_rs;
  logic [N-1:0] sh_d;
  logic         done;
  logic         carry;
  logic         err;

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, req_amt, req_fill, req_data, acc_q,
    output req_ready, sh_clr_n, sh_set_n, sh_ctrl, sh_num, sh_ls, sh_rs, sh_d,
           done, carry, err
  );

  // Control unit plus shifter side.
  modport master (
    output req_valid, req_op, req_amt, req_fill, req_data, acc_q,
    input  req_ready, sh_clr_n, sh_set_n, sh_ctrl, sh_num, sh_ls, sh_rs, sh_d,
           done, carry, err
  );
endinterface

// File: rtl/shift_cnt.sv
// 3-bit loadable down-counter tracking the remaining shifter operations of a command.
// Latency: load/dec take effect on the next clock edge; last is decoded from the register.
// Backpressure: none; load has priority over dec.
module shift_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       last
);

  logic [2:0] cnt_d, cnt_q;

  // Next count: reload on a new command, otherwise count down one per EXEC cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == 3'd1);

endmodule

// File: rtl/acc_shift_seq.sv
// Sequences one accumulator command into per-cycle shifter controls (clear/set/load/shift/rotate).
// Latency: accept at T, k EXEC cycles, done at T+k+1; zero-work ops done at T+1. Macro: ACC_ROTATE_EN.
// Backpressure: req_ready only in IDLE; req_valid elsewhere is ignored, never queued.
module acc_shift_seq
  import acc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  acc_shift_seq_if.slave       bus
);

  state_e       state_d, state_q;
  logic [2:0]   op_d, op_q;
  logic         fill_d, fill_q;
  logic [N-1:0] data_d, data_q;
  logic         carry_d, carry_q;
  logic         illegal_d, illegal_q;

  logic         cnt_load;
  logic [2:0]   cnt_ld_val;
  logic         cnt_dec;
  logic         cnt_last;

  logic         req_shift;
  logic         req_zero;

  assign req_shift = op_is_shift(bus.req_op);
  // Commands that do no shifter work go straight to DONE.
  assign req_zero  = (bus.req_op == ACC_OP_NOP) || !op_legal(bus.req_op) ||
                     (req_shift && (bus.req_amt == 3'd0));

  shift_cnt u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_ld_val),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  // Next-state, command latch and carry capture.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    fill_d     = fill_q;
    data_d     = data_q;
    carry_d    = carry_q;
    illegal_d  = illegal_q;
    cnt_load   = 1'b0;
    cnt_ld_val = 3'd1;
    cnt_dec    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d       = bus.req_op;
          fill_d     = bus.req_fill;
          data_d     = bus.req_data;
          illegal_d  = !op_legal(bus.req_op);
          cnt_load   = 1'b1;
          cnt_ld_val = req_shift ? bus.req_amt : 3'd1;
          state_d    = req_zero ? DONE : EXEC;
        end
      end
      EXEC: begin
        cnt_dec = 1'b1;
        if (op_is_shift(op_q)) begin
          carry_d = op_is_left(op_q) ? bus.acc_q[N-1] : bus.acc_q[0];
        end else begin
          carry_d = 1'b0;
        end
        if (cnt_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched command registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 3'd0;
      fill_q    <= 1'b0;
      data_q    <= '0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fill_q    <= fill_d;
      data_q    <= data_d;
      carry_q   <= carry_d;
      illegal_q <= illegal_d;
    end
  end

  // Shifter controls: inactive except during EXEC; reset forces a clear on the same edge.
  always_comb begin
    bus.sh_clr_n = 1'b1;
    bus.sh_set_n = 1'b1;
    bus.sh_ctrl  = SH_HOLD;
    bus.sh_num   = 3'd0;
    bus.sh_ls    = 1'b0;
    bus.sh_rs    = 1'b0;
    bus.sh_d     = '0;
    if (rst) begin
      bus.sh_clr_n = 1'b0;
    end else if (state_q == EXEC) begin
      case (op_q)
        ACC_OP_LOAD: begin
          bus.sh_ctrl = SH_LOAD;
          bus.sh_d    = data_q;
        end
        ACC_OP_CLR: bus.sh_clr_n = 1'b0;
        ACC_OP_SET: bus.sh_set_n = 1'b0;
        ACC_OP_SHL: begin
          bus.sh_ctrl = SH_LEFT;
          bus.sh_num  = 3'd1;
          bus.sh_ls   = fill_q;
        end
        ACC_OP_SHR: begin
          bus.sh_ctrl = SH_RIGHT;
          bus.sh_num  = 3'd1;
          bus.sh_rs   = fill_q;
        end
        ACC_OP_ROL: begin
          bus.sh_ctrl = SH_LEFT;
          bus.sh_num  = 3'd1;
          bus.sh_ls   = bus.acc_q[N-1];
        end
        ACC_OP_ROR: begin
          bus.sh_ctrl = SH_RIGHT;
          bus.sh_num  = 3'd1;
          bus.sh_rs   = bus.acc_q[0];
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.err       = (state_q == DONE) && illegal_q;
  assign bus.carry     = carry_q;

endmodule

// File: tb/tb_acc_shift_seq.sv
// Directed bench for acc_shift_seq with a behavioural 8-bit accumulator shifter on acc_q.
// Latency: table commands expect done at accept+k+1 (zero-work ops at accept+1).
// Backpressure: each command is issued only in an IDLE cycle; a stray valid during EXEC must be ignored.
module tb_acc_shift_seq;
  import acc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acc_shift_seq_if #(.N(8)) bus ();

  acc_shift_seq #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Accumulator shifter model; starts holding 0x5A so the reset clear is visible.
  logic [7:0] acc = 8'h5A;
  assign bus.acc_q = acc;

  always @(posedge clk) begin
    if (!bus.sh_clr_n) acc <= 8'h00;
    else if (!bus.sh_set_n) acc <= 8'hFF;
    else begin
      case (bus.sh_ctrl)
        SH_LOAD:  acc <= bus.sh_d;
        SH_LEFT:  if (bus.sh_num == 3'd1) acc <= {acc[6:0], bus.sh_ls};
        SH_RIGHT: if (bus.sh_num == 3'd1) acc <= {bus.sh_rs, acc[7:1]};
        default:  acc <= acc;
      endcase
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [2:0] amt;
    logic       fill;
    logic [7:0] data;
    int         lat;      // cycles from accept edge to the done cycle
    logic [7:0] e_acc;
    logic       e_carry;
    logic       e_err;
    logic [1:0] e_ctrl;   // expected shifter pins during every EXEC cycle
    logic [2:0] e_num;
    logic [7:0] e_d;
    logic       e_ls;
    logic       e_rs;
    logic       e_clr_n;
    logic       e_set_n;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic [2:0] amt, input logic fill,
                              input logic [7:0] data, input int lat, input logic [7:0] e_acc,
                              input logic e_carry, input logic e_err, input logic [1:0] e_ctrl,
                              input logic [2:0] e_num, input logic [7:0] e_d, input logic e_ls,
                              input logic e_rs, input logic e_clr_n, input logic e_set_n);
    vec_t v;
    v.op = op; v.amt = amt; v.fill = fill; v.data = data; v.lat = lat;
    v.e_acc = e_acc; v.e_carry = e_carry; v.e_err = e_err; v.e_ctrl = e_ctrl;
    v.e_num = e_num; v.e_d = e_d; v.e_ls = e_ls; v.e_rs = e_rs;
    v.e_clr_n = e_clr_n; v.e_set_n = e_set_n;
    return v;
  endfunction

  localparam int NV = 12;
  vec_t vt[NV];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    int   bad;
    logic got;

    bus.req_valid = 1'b0;
    bus.req_op    = ACC_OP_NOP;
    bus.req_amt   = 3'd0;
    bus.req_fill  = 1'b0;
    bus.req_data  = 8'h00;

    //            op           amt   fl  data  lat acc    cy  er  ctrl      num   d      ls  rs  clr set
    vt[0]  = mk(ACC_OP_LOAD, 3'd0, 0, 8'hA5, 2, 8'hA5, 0, 0, SH_LOAD,  3'd0, 8'hA5, 0, 0, 1, 1);
    vt[1]  = mk(ACC_OP_SHL,  3'd3, 0, 8'h00, 4, 8'h28, 1, 0, SH_LEFT,  3'd1, 8'h00, 0, 0, 1, 1);
    vt[2]  = mk(ACC_OP_NOP,  3'd5, 1, 8'h77, 1, 8'h28, 1, 0, SH_HOLD,  3'd0, 8'h00, 0, 0, 1, 1);
    vt[3]  = mk(ACC_OP_SHL,  3'd0, 1, 8'h00, 1, 8'h28, 1, 0, SH_HOLD,  3'd0, 8'h00, 0, 0, 1, 1);
    vt[4]  = mk(ACC_OP_LOAD, 3'd0, 0, 8'h01, 2, 8'h01, 0, 0, SH_LOAD,  3'd0, 8'h01, 0, 0, 1, 1);
`ifdef ACC_ROTATE_EN
    vt[5]  = mk(ACC_OP_ROR,  3'd1, 0, 8'h00, 2, 8'h80, 1, 0, SH_RIGHT, 3'd1, 8'h00, 0, 1, 1, 1);
`else
    vt[5]  = mk(ACC_OP_ROR,  3'd1, 0, 8'h00, 1, 8'h01, 0, 1, SH_HOLD,  3'd0, 8'h00, 0, 0, 1, 1);
`endif
    vt[6]  = mk(ACC_OP_SET,  3'd0, 0, 8'h00, 2, 8'hFF, 0, 0, SH_HOLD,  3'd0, 8'h00, 0, 0, 1, 0);
    vt[7]  = mk(ACC_OP_SHR,  3'd2, 0, 8'h00, 3, 8'h3F, 1, 0, SH_RIGHT, 3'd1, 8'h00, 0, 0, 1, 1);
    vt[8]  = mk(ACC_OP_CLR,  3'd0, 0, 8'h00, 2, 8'h00, 0, 0, SH_HOLD,  3'd0, 8'h00, 0, 0, 0, 1);
    vt[9]  = mk(ACC_OP_SHR,  3'd1, 1, 8'h00, 2, 8'h80, 0, 0, SH_RIGHT, 3'd1, 8'h00, 0, 1, 1, 1);
    vt[10] = mk(ACC_OP_SHL,  3'd4, 1, 8'h00, 5, 8'h0F, 0, 0, SH_LEFT,  3'd1, 8'h00, 1, 0, 1, 1);
`ifdef ACC_ROTATE_EN
    vt[11] = mk(ACC_OP_ROL,  3'd2, 0, 8'h00, 3, 8'h3C, 0, 0, SH_LEFT,  3'd1, 8'h00, 0, 0, 1, 1);
`else
    vt[11] = mk(ACC_OP_ROL,  3'd2, 0, 8'h00, 1, 8'h0F, 0, 1, SH_HOLD,  3'd0, 8'h00, 0, 0, 1, 1);
`endif

    // Reset held two cycles: clear is asserted throughout and the accumulator empties.
    @(negedge clk);
    chk("rst_clr_n_c0", bus.sh_clr_n, 1'b0);
    @(negedge clk);
    chk("rst_clr_n_c1", bus.sh_clr_n, 1'b0);
    chk("rst_acc", acc, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_carry", bus.carry, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_idle_clr_n", bus.sh_clr_n, 1'b1);

    // Table: issue each command from IDLE and follow it to its done pulse.
    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      chk($sformatf("v%0d_ready", i), bus.req_ready, 1'b1);
      bus.req_op    = vt[i].op;
      bus.req_amt   = vt[i].amt;
      bus.req_fill  = vt[i].fill;
      bus.req_data  = vt[i].data;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = 0;
      bad = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
        @(negedge clk);
        lat++;
        if (bus.done === 1'b1) got = 1'b1;
        else if (bus.sh_ctrl !== vt[i].e_ctrl || bus.sh_num !== vt[i].e_num ||
                 bus.sh_d !== vt[i].e_d || bus.sh_ls !== vt[i].e_ls ||
                 bus.sh_rs !== vt[i].e_rs || bus.sh_clr_n !== vt[i].e_clr_n ||
                 bus.sh_set_n !== vt[i].e_set_n || bus.req_ready !== 1'b0) bad++;
      end
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_exec_pins", i), bad, 0);
      chk($sformatf("v%0d_acc", i), acc, vt[i].e_acc);
      chk($sformatf("v%0d_carry", i), bus.carry, vt[i].e_carry);
      chk($sformatf("v%0d_err", i), bus.err, vt[i].e_err);
      chk($sformatf("v%0d_done_hold", i),
          {bus.sh_clr_n, bus.sh_set_n, bus.sh_ctrl, bus.sh_num, bus.sh_ls, bus.sh_rs, bus.sh_d, bus.req_ready},
          {1'b1, 1'b1, 2'b00, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0});
    end

    // SHR 7 fill 1 on 0x00 with a stray request in EXEC and reset in the third EXEC cycle.
    @(negedge clk);
    chk("abort_pre_acc", acc, 8'h0F);
    bus.req_op    = ACC_OP_CLR;
    bus.req_data  = 8'h00;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_clr_acc", acc, 8'h00);
    @(negedge clk);
    bus.req_op    = ACC_OP_SHR;
    bus.req_amt   = 3'd7;
    bus.req_fill  = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_exec1_ctrl", bus.sh_ctrl, SH_RIGHT);
    chk("abort_exec1_rs", bus.sh_rs, 1'b1);
    bus.req_op    = ACC_OP_LOAD;
    bus.req_data  = 8'h33;
    bus.req_valid = 1'b1;
    @(negedge clk);
    chk("abort_exec2_ignored", bus.sh_ctrl, SH_RIGHT);
    chk("abort_exec2_ready", bus.req_ready, 1'b0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_exec3_acc", acc, 8'hC0);
    rst = 1'b1;
    #1;
    chk("abort_rst_clr_n", bus.sh_clr_n, 1'b0);
    @(negedge clk);
    chk("abort_acc_cleared", acc, 8'h00);
    chk("abort_no_done", bus.done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", bus.req_ready, 1'b1);
    chk("abort_no_done2", bus.done, 1'b0);
    chk("abort_carry", bus.carry, 1'b0);
    @(negedge clk);
    chk("abort_still_idle", {bus.done, bus.req_ready, acc}, {1'b0, 1'b1, 8'h00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
